// File: rtl/cover_toggle_collector.sv
// Toggle-cover collector: sticky hit bitmap plus a valid/ready stream that
// reports each cover point's first hit as a 64-bit global cover index.
module cover_toggle_collector #(
    parameter int unsigned     WIDTH       = 23,
    parameter longint unsigned COVER_INDEX = 64'd0,
    parameter longint unsigned COVER_TOTAL = 64'd38253
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_index,
    output logic [WIDTH-1:0]             hit_map,
    output logic [$clog2(WIDTH+1)-1:0]   covered_count,
    output logic                         all_covered
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (COVER_INDEX + 64'(WIDTH) - 64'd1 >= COVER_TOTAL) begin : g_bounds_check
        $error("cover_toggle_collector: COVER_INDEX+WIDTH-1 exceeds COVER_TOTAL");
    end

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [IW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IW-1:0] p;
        p = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (v[i-1]) begin
                p = IW'(i - 1);
            end
        end
        return p;
    endfunction

    logic [WIDTH-1:0] hit_map_q,   hit_map_d;
    logic [WIDTH-1:0] pending_q,   pending_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             all_q,       all_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_index_q, out_index_d;

    logic [WIDTH-1:0] new_hits;
    logic [WIDTH-1:0] sel_mask;
    logic [IW-1:0]    sel;
    logic             load;
    logic             any_pending;

    always_comb begin
        new_hits    = valid & ~hit_map_q;
        load        = !out_valid_q || out_ready;
        any_pending = |pending_q;
        sel         = lowest_set(pending_q);
        sel_mask    = '0;
        if (load && any_pending) begin
            sel_mask = WIDTH'(1'b1) << sel;
        end

        // Selection uses registered pending only, so a fresh hit reaches the
        // stream one edge after capture; it can never collide with sel_mask.
        hit_map_d   = hit_map_q | valid;
        pending_d   = (pending_q & ~sel_mask) | new_hits;
        count_d     = count_q + popcount(new_hits);
        all_d       = (count_d == CW'(WIDTH));

        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        if (load) begin
            out_valid_d = any_pending;
            if (any_pending) begin
                out_index_d = COVER_INDEX + 64'(sel);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hit_map_q   <= '0;
            pending_q   <= '0;
            count_q     <= '0;
            all_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            hit_map_q   <= hit_map_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            all_q       <= all_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign hit_map       = hit_map_q;
    assign covered_count = count_q;
    assign all_covered   = all_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: directed scenarios plus random traffic,
// every cycle compared with a set-based reference model.
module tb_cover_toggle_collector;

    localparam int              W  = 23;
    localparam longint unsigned CI = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic [W-1:0]  valid;
    logic          out_ready;
    logic          out_valid;
    logic [63:0]   out_index;
    logic [W-1:0]  hit_map;
    logic [4:0]    covered_count;
    logic          all_covered;

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .WIDTH(W),
        .COVER_INDEX(CI),
        .COVER_TOTAL(64'd38253)
    ) dut (
        .clock(clock),
        .reset(reset),
        .valid(valid),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .hit_map(hit_map),
        .covered_count(covered_count),
        .all_covered(all_covered)
    );

    // Reference model: sets of seen and waiting points, and the current beat.
    bit              m_seen[W];
    bit              m_wait[W];
    int              m_cnt;
    bit              m_ov;
    longint unsigned m_oi;

    int passed = 0;
    int total  = 0;

    int beats;
    int dups;
    bit beat_seen[W];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge();
        int p;
        if (reset || clear) begin
            for (int b = 0; b < W; b++) begin
                m_seen[b] = 1'b0;
                m_wait[b] = 1'b0;
            end
            m_cnt = 0;
            m_ov  = 1'b0;
            m_oi  = 0;
        end else begin
            if (!m_ov || out_ready) begin
                p = -1;
                for (int b = W - 1; b >= 0; b--) begin
                    if (m_wait[b]) p = b;
                end
                if (p >= 0) begin
                    m_wait[p] = 1'b0;
                    m_oi      = CI + longint'(p);
                    m_ov      = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int b = 0; b < W; b++) begin
                if (valid[b] && !m_seen[b]) begin
                    m_seen[b] = 1'b1;
                    m_wait[b] = 1'b1;
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic step();
        logic [W-1:0]    hm;
        longint unsigned d;
        if (out_valid === 1'b1 && out_ready && !reset && !clear) begin
            beats++;
            d = out_index - CI;
            if (d < W) begin
                if (beat_seen[d]) dups++;
                beat_seen[d] = 1'b1;
            end else begin
                dups++;
            end
        end
        @(posedge clock);
        model_edge();
        #1;
        for (int b = 0; b < W; b++) hm[b] = m_seen[b];
        check("model_out_valid", out_valid, m_ov);
        check("model_out_index", out_index, m_oi);
        check("model_hit_map", hit_map, hm);
        check("model_covered_count", covered_count, m_cnt);
        check("model_all_covered", all_covered, m_cnt == W);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", covered_count, 0);
    endtask

    initial begin
        int ord[W];
        int tmp;
        int j;
        int k;
        int i;
        int seen_n;

        // Reset with all strobes high: everything must stay clear.
        reset = 1'b1; clear = 1'b0; valid = '1; out_ready = 1'b1;
        beats = 0; dups = 0;
        repeat (3) step();
        reset = 1'b0; valid = '0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_hit_map", hit_map, 0);
        check("rst_count", covered_count, 0);
        check("rst_out_index", out_index, 0);

        // Single hit, 2-cycle latency, repeat hit ignored.
        valid[5] = 1'b1; step(); valid = '0;
        check("t2_count_e0", covered_count, 1);
        check("t2_ov_e0", out_valid, 0);
        step();
        check("t2_ov_e1", out_valid, 1);
        check("t2_idx", out_index, 105);
        step();
        check("t2_ov_e2", out_valid, 0);
        repeat (3) step();
        valid[5] = 1'b1; step(); valid = '0;
        step();
        check("t2_rehit_ov", out_valid, 0);
        step();
        check("t2_rehit_ov2", out_valid, 0);
        check("t2_rehit_count", covered_count, 1);
        do_clear();

        // Three simultaneous hits, reported in ascending order.
        valid = 23'h400009; step(); valid = '0;
        check("t3_count", covered_count, 3);
        check("t3_ov_e0", out_valid, 0);
        step(); check("t3_ov_a", out_valid, 1); check("t3_idx_a", out_index, 100);
        step(); check("t3_ov_b", out_valid, 1); check("t3_idx_b", out_index, 103);
        step(); check("t3_ov_c", out_valid, 1); check("t3_idx_c", out_index, 122);
        step(); check("t3_ov_end", out_valid, 0);
        do_clear();

        // Backpressure: held beat stays stable, lower bit waits.
        out_ready = 1'b0;
        valid[7] = 1'b1; valid[2] = 1'b1; step(); valid = '0;
        step();
        check("t4_ov", out_valid, 1);
        check("t4_idx", out_index, 102);
        valid[0] = 1'b1; step(); valid = '0;
        check("t4_hold_idx", out_index, 102);
        repeat (3) begin
            step();
            check("t4_hold_ov", out_valid, 1);
            check("t4_hold_idx2", out_index, 102);
        end
        out_ready = 1'b1;
        step(); check("t4_idx_100", out_index, 100); check("t4_ov_100", out_valid, 1);
        step(); check("t4_idx_107", out_index, 107); check("t4_ov_107", out_valid, 1);
        step(); check("t4_ov_end", out_valid, 0);
        do_clear();

        // Every point hit in random order and grouping.
        beats = 0; dups = 0;
        for (int b = 0; b < W; b++) begin
            beat_seen[b] = 1'b0;
            ord[b] = b;
        end
        for (int b = W - 1; b > 0; b--) begin
            j = $urandom_range(0, b);
            tmp = ord[b]; ord[b] = ord[j]; ord[j] = tmp;
        end
        i = 0;
        while (i < W) begin
            valid = '0;
            k = $urandom_range(1, 3);
            for (int n = 0; n < k && i < W; n++) begin
                valid[ord[i]] = 1'b1;
                i++;
            end
            step();
            valid = '0;
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (30) step();
        seen_n = 0;
        for (int b = 0; b < W; b++) seen_n += int'(beat_seen[b]);
        check("t5_beats", beats, 23);
        check("t5_dups", dups, 0);
        check("t5_distinct", seen_n, 23);
        check("t5_all_covered", all_covered, 1);
        check("t5_count", covered_count, 23);
        do_clear();

        // Clear discards an unaccepted beat and wins over a same-cycle hit.
        out_ready = 1'b0;
        valid[3] = 1'b1; step(); valid = '0;
        step();
        check("t6_pre_ov", out_valid, 1);
        check("t6_pre_idx", out_index, 103);
        clear = 1'b1; valid[9] = 1'b1; step();
        clear = 1'b0; valid = '0;
        check("t6_ov", out_valid, 0);
        check("t6_hit_map", hit_map, 0);
        check("t6_count", covered_count, 0);
        check("t6_idx", out_index, 0);
        out_ready = 1'b1;
        step();
        check("t6_dropped", out_valid, 0);
        valid[9] = 1'b1; step(); valid = '0;
        step();
        check("t6_rehit_ov", out_valid, 1);
        check("t6_rehit_idx", out_index, 109);

        // Random traffic with random backpressure, clears and resets.
        repeat (3000) begin
            valid = ($urandom_range(0, 3) == 0) ? (W'($urandom) & W'($urandom) & W'($urandom)) : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b1;
        repeat (30) step();
        check("final_drain_ov", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
